// File: rtl/dcache_mshr.sv
// dcache_mshr: miss status holding registers for the data cache.
// Tracks outstanding block misses, merges repeat misses and issues block loads.
module dcache_mshr #(
   parameter int MSHR_ENTRIES = 4,
   parameter int BLK_ADDR_W = 13,
   parameter int DATA_W = 64
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  miss_valid,
   input  logic [BLK_ADDR_W-1:0] miss_addr,
   input  logic                  miss_is_store,
   input  logic [DATA_W-1:0]     miss_store_data,
   output logic                  miss_ready,
   output logic [1:0]            mem_command,
   output logic [BLK_ADDR_W-1:0] mem_addr,
   input  logic [3:0]            mem_response,
   input  logic [3:0]            mem_tag,
   input  logic [DATA_W-1:0]     mem_data,
   output logic                  fill_valid,
   output logic [BLK_ADDR_W-1:0] fill_addr,
   output logic [DATA_W-1:0]     fill_data,
   output logic                  fill_dirty,
   output logic [3:0]            outstanding
);
   localparam int IW = $clog2(MSHR_ENTRIES);
   typedef enum logic [1:0] {INVALID, WAIT_ISSUE, WAIT_DATA} state_t;
   state_t                state [MSHR_ENTRIES];
   logic [BLK_ADDR_W-1:0] addr [MSHR_ENTRIES];
   logic                  is_store [MSHR_ENTRIES];
   logic [DATA_W-1:0]     store_data [MSHR_ENTRIES];
   logic [3:0]            tag [MSHR_ENTRIES];
   logic done, issue, hit, free;
   logic [IW-1:0] done_idx, issue_idx, hit_idx, free_idx;
   logic [3:0] count;
   // Scanning from the top down leaves the lowest matching index in each *_idx.
   always_comb begin
      done = 1'b0;
      done_idx = '0;
      issue = 1'b0;
      issue_idx = '0;
      hit = 1'b0;
      hit_idx = '0;
      free = 1'b0;
      free_idx = '0;
      count = '0;
      for (int i = MSHR_ENTRIES - 1; i >= 0; i--) begin
         if (state[i] == WAIT_DATA && mem_tag != 4'd0 && tag[i] == mem_tag) begin
            done = 1'b1;
            done_idx = IW'(i);
         end
         if (state[i] == WAIT_ISSUE) begin
            issue = 1'b1;
            issue_idx = IW'(i);
         end
         if (state[i] == INVALID) begin
            free = 1'b1;
            free_idx = IW'(i);
         end
         count = count + 4'(state[i] != INVALID);
      end
      // The completing entry is no merge target; such a miss refetches instead.
      for (int i = MSHR_ENTRIES - 1; i >= 0; i--) begin
         if (state[i] != INVALID && addr[i] == miss_addr && !(done && done_idx == IW'(i))) begin
            hit = 1'b1;
            hit_idx = IW'(i);
         end
      end
   end
   assign miss_ready = hit || free;
   assign mem_command = issue ? 2'd1 : 2'd0;
   assign mem_addr = issue ? addr[issue_idx] : '0;
   assign outstanding = count;
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < MSHR_ENTRIES; i++) state[i] <= INVALID;
         fill_valid <= 1'b0;
         fill_addr <= '0;
         fill_data <= '0;
         fill_dirty <= 1'b0;
      end else begin
         fill_valid <= done;
         fill_addr <= done ? addr[done_idx] : '0;
         fill_data <= done ? (is_store[done_idx] ? store_data[done_idx] : mem_data) : '0;
         fill_dirty <= done && is_store[done_idx];
         if (done) state[done_idx] <= INVALID;
         if (issue && mem_response != 4'd0) begin
            state[issue_idx] <= WAIT_DATA;
            tag[issue_idx] <= mem_response;
         end
         if (miss_valid && hit && miss_is_store) begin
            is_store[hit_idx] <= 1'b1;
            store_data[hit_idx] <= miss_store_data;
         end else if (miss_valid && !hit && free) begin
            state[free_idx] <= WAIT_ISSUE;
            addr[free_idx] <= miss_addr;
            is_store[free_idx] <= miss_is_store;
            store_data[free_idx] <= miss_store_data;
         end
      end
   end
endmodule

// File: tb/tb_dcache_mshr.sv
// tb_dcache_mshr: directed scenarios plus random traffic against a behavioural MSHR model.
module tb_dcache_mshr;
   logic        clock, reset, miss_valid, miss_is_store, miss_ready;
   logic [12:0] miss_addr, mem_addr, fill_addr;
   logic [63:0] miss_store_data, mem_data, fill_data;
   logic [1:0]  mem_command;
   logic [3:0]  mem_response, mem_tag, outstanding;
   logic        fill_valid, fill_dirty;
   int total = 0, passed = 0;
   int          m_st [4];
   logic [12:0] m_addr [4];
   logic        m_store [4];
   logic [63:0] m_sd [4];
   logic [3:0]  m_tg [4];
   logic        s_ready;
   logic [1:0]  s_cmd;
   logic [12:0] s_addr;

   dcache_mshr dut (
      .clock(clock), .reset(reset), .miss_valid(miss_valid), .miss_addr(miss_addr),
      .miss_is_store(miss_is_store), .miss_store_data(miss_store_data), .miss_ready(miss_ready),
      .mem_command(mem_command), .mem_addr(mem_addr), .mem_response(mem_response),
      .mem_tag(mem_tag), .mem_data(mem_data), .fill_valid(fill_valid), .fill_addr(fill_addr),
      .fill_data(fill_data), .fill_dirty(fill_dirty), .outstanding(outstanding)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // One clock: drive inputs, compare combinational outputs, clock, advance model, compare registered outputs.
   task automatic step(input logic rst, input logic mv, input logic [12:0] ma, input logic ms,
                       input logic [63:0] md, input logic [3:0] rsp, input logic [3:0] tg,
                       input logic [63:0] dat);
      int c = -1, iss = -1, hit = -1, fr = -1, cnt = 0;
      logic [12:0] e_fa = '0;
      logic [63:0] e_fd = '0;
      logic e_fv = 1'b0, e_dirty = 1'b0;
      reset = rst; miss_valid = mv; miss_addr = ma; miss_is_store = ms; miss_store_data = md;
      mem_response = rsp; mem_tag = tg; mem_data = dat;
      #1;
      for (int i = 0; i < 4; i++) begin
         if (c < 0 && tg != 0 && m_st[i] == 2 && m_tg[i] == tg) c = i;
         if (iss < 0 && m_st[i] == 1) iss = i;
         if (fr < 0 && m_st[i] == 0) fr = i;
      end
      for (int i = 0; i < 4; i++) if (hit < 0 && i != c && m_st[i] != 0 && m_addr[i] == ma) hit = i;
      s_ready = miss_ready; s_cmd = mem_command; s_addr = mem_addr;
      chk("miss_ready", s_ready, (hit >= 0 || fr >= 0));
      chk("mem_command", s_cmd, iss >= 0 ? 2'd1 : 2'd0);
      chk("mem_addr", s_addr, iss >= 0 ? m_addr[iss] : 13'd0);
      @(posedge clock);
      if (rst) begin
         for (int i = 0; i < 4; i++) m_st[i] = 0;
      end else begin
         if (c >= 0) begin
            e_fv = 1'b1; e_fa = m_addr[c]; e_dirty = m_store[c];
            e_fd = m_store[c] ? m_sd[c] : dat;
            m_st[c] = 0;
         end
         if (iss >= 0 && rsp != 0) begin m_st[iss] = 2; m_tg[iss] = rsp; end
         if (mv && hit >= 0) begin
            if (ms) begin m_store[hit] = 1'b1; m_sd[hit] = md; end
         end else if (mv && fr >= 0) begin
            m_st[fr] = 1; m_addr[fr] = ma; m_store[fr] = ms; m_sd[fr] = md;
         end
      end
      for (int i = 0; i < 4; i++) cnt += int'(m_st[i] != 0);
      #1;
      chk("fill_valid", fill_valid, e_fv);
      chk("fill_addr", fill_addr, e_fa);
      chk("fill_data", fill_data, e_fd);
      chk("fill_dirty", fill_dirty, e_dirty);
      chk("outstanding", outstanding, 4'(cnt));
   endtask

   task automatic idle(input logic [3:0] rsp, input logic [3:0] tg, input logic [63:0] dat);
      step(1'b0, 1'b0, 13'd0, 1'b0, 64'd0, rsp, tg, dat);
   endtask

   task automatic miss(input logic [12:0] ma, input logic ms, input logic [63:0] md, input logic [3:0] rsp);
      step(1'b0, 1'b1, ma, ms, md, rsp, 4'd0, 64'd0);
   endtask

   initial begin
      for (int i = 0; i < 4; i++) m_st[i] = 0;
      reset = 1'b1; miss_valid = 1'b0; miss_addr = '0; miss_is_store = 1'b0;
      miss_store_data = '0; mem_response = '0; mem_tag = '0; mem_data = '0;
      repeat (2) @(posedge clock);
      #1;
      chk("reset_outstanding", outstanding, 4'd0);
      chk("reset_fill_valid", fill_valid, 1'b0);
      chk("reset_ready", miss_ready, 1'b1);
      chk("reset_cmd", mem_command, 2'd0);
      // Basic load miss.
      miss(13'h0A5, 1'b0, 64'd0, 4'd0);
      chk("l_cmd_before", s_cmd, 2'd0);
      chk("l_out1", outstanding, 4'd1);
      idle(4'd3, 4'd0, 64'd0);
      chk("l_cmd", s_cmd, 2'd1);
      chk("l_addr", s_addr, 13'h0A5);
      idle(4'd0, 4'd3, 64'h1234);
      chk("l_fv", fill_valid, 1'b1);
      chk("l_fd", fill_data, 64'h1234);
      chk("l_dirty", fill_dirty, 1'b0);
      chk("l_out0", outstanding, 4'd0);
      // Rejected issue retries.
      miss(13'h0A5, 1'b0, 64'd0, 4'd0);
      idle(4'd0, 4'd0, 64'd0);
      chk("r_cmd1", s_cmd, 2'd1);
      idle(4'd0, 4'd0, 64'd0);
      chk("r_addr2", s_addr, 13'h0A5);
      idle(4'd5, 4'd0, 64'd0);
      chk("r_cmd3", s_cmd, 2'd1);
      idle(4'd0, 4'd0, 64'd0);
      chk("r_cmd_done", s_cmd, 2'd0);
      idle(4'd0, 4'd5, 64'h55);
      chk("r_fill", fill_data, 64'h55);
      // Store merge.
      miss(13'h010, 1'b0, 64'd0, 4'd0);
      miss(13'h010, 1'b1, 64'hBEEF, 4'd0);
      chk("m_out", outstanding, 4'd1);
      idle(4'd7, 4'd0, 64'd0);
      idle(4'd0, 4'd7, 64'h9999);
      chk("m_fd", fill_data, 64'hBEEF);
      chk("m_dirty", fill_dirty, 1'b1);
      // Full table.
      for (int a = 1; a <= 4; a++) miss(13'(a), 1'b0, 64'd0, 4'd0);
      chk("f_out4", outstanding, 4'd4);
      idle(4'd0, 4'd0, 64'd0);
      step(1'b0, 1'b0, 13'h5, 1'b0, 64'd0, 4'd0, 4'd0, 64'd0);
      chk("f_ready_new", s_ready, 1'b0);
      miss(13'h2, 1'b0, 64'd0, 4'd0);
      chk("f_ready_merge", s_ready, 1'b1);
      idle(4'd9, 4'd0, 64'd0);
      miss(13'h5, 1'b0, 64'd0, 4'd0);
      idle(4'd0, 4'd9, 64'hAA);
      chk("f_fill_addr", fill_addr, 13'h1);
      miss(13'h5, 1'b0, 64'd0, 4'd0);
      chk("f_ready_after", s_ready, 1'b1);
      chk("f_out_after", outstanding, 4'd4);
      step(1'b1, 1'b0, 13'd0, 1'b0, 64'd0, 4'd0, 4'd0, 64'd0);
      // Out-of-order return.
      miss(13'h1, 1'b0, 64'd0, 4'd0);
      miss(13'h2, 1'b0, 64'd0, 4'd1);
      idle(4'd2, 4'd0, 64'd0);
      idle(4'd0, 4'd2, 64'h22);
      chk("o_first", fill_addr, 13'h2);
      idle(4'd0, 4'd1, 64'h11);
      chk("o_second", fill_addr, 13'h1);
      chk("o_data", fill_data, 64'h11);
      // Reset discards in-flight entries.
      miss(13'h1, 1'b0, 64'd0, 4'd0);
      miss(13'h2, 1'b0, 64'd0, 4'd1);
      idle(4'd2, 4'd0, 64'd0);
      step(1'b1, 1'b0, 13'd0, 1'b0, 64'd0, 4'd0, 4'd0, 64'd0);
      idle(4'd0, 4'd1, 64'h77);
      chk("x_fv", fill_valid, 1'b0);
      chk("x_out", outstanding, 4'd0);
      // Random traffic with a small address and tag space to force merges and tag collisions.
      for (int k = 0; k < 800; k++)
         step($urandom_range(0, 60) == 0, $urandom_range(0, 2) != 0, 13'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), {$urandom, $urandom},
              $urandom_range(0, 1) ? 4'($urandom_range(1, 6)) : 4'd0,
              $urandom_range(0, 3) == 0 ? 4'd0 : 4'($urandom_range(1, 6)), {$urandom, $urandom});
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
